calc_request_arbiter: RTL and testbench

//  Shares one small-calculator datapath/control unit between two requesters.

---
 rtl/calc_request_arbiter.sv | 114 +++++++++++
 tb/tb_calc_request_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_request_arbiter.sv
// calc_request_arbiter: round-robin arbiter sharing one calculator between two requesters,
// with a done timeout that returns an error response and pulses calc_rst.
module calc_request_arbiter #(
    parameter int DW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    op0,
    input  logic [1:0]    op1,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b0,
    input  logic [DW-1:0] b1,
    output logic [1:0]    gnt,
    output logic [1:0]    rsp_valid,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          calc_go,
    output logic [1:0]    calc_op,
    output logic [DW-1:0] calc_a,
    output logic [DW-1:0] calc_b,
    output logic          calc_rst,
    input  logic          calc_done,
    input  logic [DW-1:0] calc_result
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d, owner_q, owner_d, err_q, err_d, win;
    logic [7:0]    timer_q, timer_d;
    logic [1:0]    op_q, op_d;
    logic [DW-1:0] ca_q, ca_d, cb_q, cb_d, data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
            op_q    <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            op_q    <= op_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        err_d   = err_q;
        timer_d = timer_q;
        op_d    = op_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        data_d  = data_q;
        // a lone request wins outright; a tie goes to the round-robin pointer
        win     = (req == 2'b11) ? rr_q : req[1];
        case (state_q)
            IDLE: if (req != 2'b00) begin
                owner_d = win;
                op_d    = win ? op1 : op0;
                ca_d    = win ? a1 : a0;
                cb_d    = win ? b1 : b0;
                state_d = ISSUE;
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: if (calc_done) begin
                data_d  = calc_result;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (timer_q == 8'(TIMEOUT - 1)) begin
                data_d  = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                timer_d = timer_q + 8'd1;
            end
            RESP: begin
                rr_d    = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = state_q != IDLE;
    assign calc_go   = state_q == ISSUE;
    assign gnt       = calc_go ? {owner_q, ~owner_q} : 2'b00;
    assign rsp_valid = (state_q == RESP) ? {owner_q, ~owner_q} : 2'b00;
    assign calc_rst  = (state_q == RESP) & err_q;
    assign rsp_err   = err_q;
    assign rsp_data  = data_q;
    assign calc_op   = op_q;
    assign calc_a    = ca_q;
    assign calc_b    = cb_q;
endmodule

// File: tb/tb_calc_request_arbiter.sv
// tb_calc_request_arbiter: randomized bench with a transaction-schedule model of the arbiter
// and a latency-programmable calculator model; directed cases pin the model with literals.
module tb_calc_request_arbiter;
    localparam int DW  = 4;
    localparam int TO  = 15;
    localparam int BIG = 1 << 30;

    logic          clk = 1'b0, rst = 1'b0;
    logic [1:0]    req = '0, op0 = '0, op1 = '0;
    logic [DW-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [1:0]    gnt, rsp_valid, calc_op;
    logic          rsp_err, busy, calc_go, calc_rst;
    logic [DW-1:0] rsp_data, calc_a, calc_b;
    logic          calc_done = 1'b0;
    logic [DW-1:0] calc_result = '0;

    calc_request_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .busy(busy), .calc_go(calc_go), .calc_op(calc_op), .calc_a(calc_a),
        .calc_b(calc_b), .calc_rst(calc_rst), .calc_done(calc_done),
        .calc_result(calc_result)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0;
    // model: a transaction is an issue cycle and a response cycle (BIG while pending)
    int m_issue = -10, m_resp = -5;
    bit m_owner, m_rr, m_err;
    logic [1:0]    m_op;
    logic [DW-1:0] m_a, m_b, m_data;
    // calculator model
    bit pend, rnd_lat;
    int done_at, lat = 5, stray_pct = 0, n_crst = 0;
    int g_own[$], g_cyc[$], r_own[$], r_cyc[$], r_data[$], r_err[$];

    function automatic logic [DW-1:0] alu(logic [1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op)
            2'd3:    return a + b;
            2'd2:    return a - b;
            2'd1:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic bit m_idle(int x);
        return !(m_issue <= x && x <= m_resp);
    endfunction

    function automatic int qg(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_outputs();
        bit is_i = (cyc == m_issue), is_r = (cyc == m_resp);
        chk("gnt", 32'(gnt), is_i ? (m_owner ? 2 : 1) : 0);
        chk("calc_go", 32'(calc_go), 32'(is_i));
        chk("rsp_valid", 32'(rsp_valid), is_r ? (m_owner ? 2 : 1) : 0);
        chk("calc_rst", 32'(calc_rst), 32'(is_r && m_err));
        chk("busy", 32'(busy), 32'(!m_idle(cyc)));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        chk("calc_op", 32'(calc_op), 32'(m_op));
        chk("calc_a", 32'(calc_a), 32'(m_a));
        chk("calc_b", 32'(calc_b), 32'(m_b));
    endtask

    task automatic model_next();
        if (m_idle(cyc) && req != 2'b00) begin
            m_owner = (req == 2'b11) ? m_rr : req[1];
            m_op    = m_owner ? op1 : op0;
            m_a     = m_owner ? a1 : a0;
            m_b     = m_owner ? b1 : b0;
            m_issue = cyc + 1;
            m_resp  = BIG;
        end else if (m_resp == BIG && cyc > m_issue) begin
            if (calc_done) begin
                m_resp = cyc + 1; m_err = 0; m_data = alu(m_op, m_a, m_b);
            end else if (cyc == m_issue + TO) begin
                m_resp = cyc + 1; m_err = 1; m_data = '0;
            end
        end else if (cyc == m_resp) begin
            m_rr = !m_owner;
        end
    endtask

    task automatic calc_drive();
        if (calc_rst) pend = 0;
        if (calc_go) begin
            if (rnd_lat) begin
                int r = $urandom_range(13);
                lat = (r == 13) ? 20 : r;
            end
            pend    = (lat != 0);
            done_at = cyc + lat;
        end
        calc_done   = 1'b0;
        calc_result = DW'($urandom);
        if (pend && cyc == done_at) begin
            calc_done   = 1'b1;
            calc_result = alu(calc_op, calc_a, calc_b);
            pend        = 0;
        end else if (!pend && m_idle(cyc) && $urandom_range(99) < stray_pct) begin
            calc_done = 1'b1;
        end
    endtask

    task automatic step();
        model_next();
        @(negedge clk);
        cyc++;
        check_outputs();
        if (gnt != 2'b00) begin g_own.push_back(int'(gnt[1])); g_cyc.push_back(cyc); end
        if (rsp_valid != 2'b00) begin
            r_own.push_back(int'(rsp_valid[1])); r_cyc.push_back(cyc);
            r_data.push_back(int'(rsp_data)); r_err.push_back(int'(rsp_err));
        end
        if (calc_rst) n_crst++;
        calc_drive();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic wait_rsp(string name, int cnt, int budget);
        int target = r_own.size() + cnt;
        for (int i = 0; i < budget && r_own.size() < target; i++) step();
        chk(name, r_own.size(), target);
    endtask

    task automatic clear_logs();
        g_own.delete(); g_cyc.delete(); r_own.delete(); r_cyc.delete();
        r_data.delete(); r_err.delete(); n_crst = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_calc_go", 32'(calc_go), 0);
        chk("rst_calc_rst", 32'(calc_rst), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_calc_op", 32'(calc_op), 0);
        chk("rst_calc_a", 32'(calc_a), 0);
        chk("rst_calc_b", 32'(calc_b), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        m_issue = -10; m_resp = -5; m_rr = 0; m_owner = 0; m_err = 0;
        m_data = '0; m_op = '0; m_a = '0; m_b = '0;
        pend = 0; calc_done = 1'b0;
        check_outputs();
    endtask

    initial begin
        int c0, nr;
        // T1: single request, nominal 5-cycle calculator
        do_reset();
        clear_logs();
        lat = 5; req = 2'b01; op0 = 2'd3; a0 = 4'd5; b0 = 4'd6; c0 = cyc;
        step(); req = 2'b00;
        run(9);
        chk("t1_gnt_cycle", qg(g_cyc, 0) - c0, 1);
        chk("t1_gnt_owner", qg(g_own, 0), 0);
        chk("t1_rsp_cycle", qg(r_cyc, 0) - c0, 7);
        chk("t1_rsp_data", qg(r_data, 0), 11);
        chk("t1_rsp_err", qg(r_err, 0), 0);
        // T2: both held, alternating service
        do_reset();
        clear_logs();
        lat = 3; req = 2'b11;
        op0 = 2'd2; a0 = 4'd9; b0 = 4'd4; op1 = 2'd1; a1 = 4'd12; b1 = 4'd10;
        for (int i = 0; i < 100 && r_own.size() < 3; i++) step();
        req = 2'b00;
        run(3);
        chk("t2_gnt0", qg(g_own, 0), 0);
        chk("t2_gnt1", qg(g_own, 1), 1);
        chk("t2_gnt2", qg(g_own, 2), 0);
        chk("t2_rsp0", qg(r_data, 0), 5);
        chk("t2_rsp1", qg(r_data, 1), 8);
        chk("t2_rsp2", qg(r_data, 2), 5);
        chk("t2_rsp_owner1", qg(r_own, 1), 1);
        // T3: hung calculator times out after 15 WAIT cycles
        clear_logs();
        lat = 0; req = 2'b01; op0 = 2'd3; a0 = 4'd1; b0 = 4'd1;
        step(); req = 2'b00;
        wait_rsp("t3_wait", 1, 40);
        run(3);
        chk("t3_resp_minus_gnt", qg(r_cyc, 0) - qg(g_cyc, 0), TO + 1);
        chk("t3_rsp_err", qg(r_err, 0), 1);
        chk("t3_rsp_data", qg(r_data, 0), 0);
        chk("t3_calc_rst_pulses", n_crst, 1);
        // T4: requester 1 arrives while requester 0 is served
        clear_logs();
        lat = 5; req = 2'b01; op1 = 2'd0; a1 = 4'd6; b1 = 4'd3;
        step(); req = 2'b00;
        run(2); req = 2'b10;
        for (int i = 0; i < 30 && g_own.size() < 2; i++) step();
        req = 2'b00;
        wait_rsp("t4_wait", 1, 30);
        chk("t4_gnt1_owner", qg(g_own, 1), 1);
        chk("t4_gnt1_after_resp", qg(g_cyc, 1) - qg(r_cyc, 0), 2);
        chk("t4_rsp1_data", qg(r_data, 1), 5);
        // T5: reset during WAIT, pointer returns to requester 0
        do_reset();
        clear_logs();
        lat = 5; req = 2'b01; op0 = 2'd3; a0 = 4'd5; b0 = 4'd6;
        step(); req = 2'b00;
        wait_rsp("t5_first", 1, 20);
        lat = 0; req = 2'b01;
        step(); req = 2'b00;
        run(4);
        nr = r_own.size();
        do_reset();
        run(5);
        chk("t5_no_rsp", r_own.size(), nr);
        clear_logs();
        lat = 3; req = 2'b11;
        run(2); req = 2'b00;
        wait_rsp("t5_after", 1, 30);
        chk("t5_first_gnt_owner", qg(g_own, 0), 0);
        // T6: stray done while idle
        clear_logs();
        run(2);
        calc_done = 1'b1;
        step();
        run(4);
        chk("t6_no_rsp", r_own.size(), 0);
        chk("t6_no_gnt", g_own.size(), 0);
        // random traffic
        clear_logs();
        rnd_lat = 1; stray_pct = 10;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) if ($urandom_range(3) == 0) req[k] = ~req[k];
            op0 = 2'($urandom); op1 = 2'($urandom);
            a0 = DW'($urandom); a1 = DW'($urandom); b0 = DW'($urandom); b1 = DW'($urandom);
            if ($urandom_range(499) == 0) do_reset();
            else step();
        end
        req = 2'b00;
        run(40);
        chk("rnd_rsps_seen", 32'(r_own.size() > 20), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
